// File: rtl/mdu_unit_pkg.sv
// Shared MDU opcodes, default latencies and opcode-class helpers.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_unit_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// IDLE/BUSY sequencer for long MDU ops: loads a down-counter at launch and
// pulses commit_o on the final busy cycle.
module mdu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       launch_i,
  input  logic [3:0] cyc_i,
  output logic       busy_o,
  output logic       commit_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_i) begin
          cnt_d   = cyc_i;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit_o = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q == S_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: computes the result at launch, holds it in
// pending registers, and commits to HI/LO when mdu_ctrl finishes. MDU_MADD_EN optional.
module mdu_unit #(
  parameter int MULT_CYCLES = mdu_unit_pkg::MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = mdu_unit_pkg::DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic        busy_o,
  output logic        stall_req_o,
  output logic [31:0] hilo_rd_o
);
  import mdu_unit_pkg::*;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic        commit_en_q, commit_en_d;
  logic        mul_start, div_start, launch, commit;
  logic [3:0]  cyc_sel;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] div_a, div_b, q_mag, r_mag, quo, rem;
  logic        div_signed;

  assign mul_start   = start_i & is_mul_op(mdu_op_i);
  assign div_start   = start_i & is_div_op(mdu_op_i);
  assign launch      = (mul_start | div_start) & ~busy_o;
  assign stall_req_o = busy_o | mul_start | div_start;
  assign cyc_sel     = div_start ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  assign hilo_rd_o   = (mdu_op_i == OP_MFHI) ? hi_q : lo_q;

  mdu_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .launch_i (launch),
    .cyc_i    (cyc_sel),
    .busy_o   (busy_o),
    .commit_o (commit)
  );

  assign prod_s = $signed({{32{rs_val_i[31]}}, rs_val_i}) *
                  $signed({{32{rt_val_i[31]}}, rt_val_i});
  assign prod_u = {32'd0, rs_val_i} * {32'd0, rt_val_i};

  // One unsigned divider for both flavours: signed divide works on magnitudes,
  // which also makes 0x80000000 / -1 come out as 0x80000000 rem 0.
  assign div_signed = (mdu_op_i == OP_DIV);
  always_comb begin
    div_a = (div_signed && rs_val_i[31]) ? -rs_val_i : rs_val_i;
    div_b = (div_signed && rt_val_i[31]) ? -rt_val_i : rt_val_i;
    if (div_b == 32'd0) div_b = 32'd1;
    q_mag = div_a / div_b;
    r_mag = div_a % div_b;
    quo   = (div_signed && (rs_val_i[31] ^ rt_val_i[31])) ? -q_mag : q_mag;
    rem   = (div_signed && rs_val_i[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    res = 64'd0;
    case (mdu_op_i)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV,
      OP_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

  always_comb begin
    hi_pend_d   = hi_pend_q;
    lo_pend_d   = lo_pend_q;
    commit_en_d = commit_en_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (launch) begin
      hi_pend_d   = res[63:32];
      lo_pend_d   = res[31:0];
      commit_en_d = ~(div_start && (rt_val_i == 32'd0));
    end
    if (commit && commit_en_q) begin
      hi_d = hi_pend_q;
      lo_d = lo_pend_q;
    end else if (start_i && !busy_o) begin
      if (mdu_op_i == OP_MTHI) hi_d = rs_val_i;
      if (mdu_op_i == OP_MTLO) lo_d = rs_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      hi_pend_q   <= 32'd0;
      lo_pend_q   <= 32'd0;
      commit_en_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      hi_pend_q   <= hi_pend_d;
      lo_pend_q   <= lo_pend_d;
      commit_en_q <= commit_en_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected busy/stall/read
// values; a negedge monitor pops and compares.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int K_BUSY = 0, K_STALL = 1, K_HI = 2, K_LO = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  mdu_op_i = OP_NOP;
  logic [31:0] rs_val_i = '0, rt_val_i = '0;
  logic        busy_o, stall_req_o;
  logic [31:0] hilo_rd_o;

  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_act;
  logic probe_vld = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mdu_op_i(mdu_op_i),
    .rs_val_i(rs_val_i), .rt_val_i(rt_val_i), .busy_o(busy_o),
    .stall_req_o(stall_req_o), .hilo_rd_o(hilo_rd_o)
  );

  always @(negedge clk) begin
    if (probe_vld) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: probe with no expectation");
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          K_BUSY:  mon_act = {31'd0, busy_o};
          K_STALL: mon_act = {31'd0, stall_req_o};
          default: mon_act = hilo_rd_o;
        endcase
        if ((mon_e.kind == K_HI || mon_e.kind == K_LO) && stall_req_o !== 1'b0) begin
          failures++;
          $display("FAIL %s: read while stall_req_o=%b, required 0", mon_e.name, stall_req_o);
        end else if (mon_act !== mon_e.val) begin
          failures++;
          $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.val);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
    probe_vld = 1'b0;
    start_i   = 1'b0;
    mdu_op_i  = OP_NOP;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
    probe_vld = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic stl, input string name);
    start_i = 1'b1; mdu_op_i = op; rs_val_i = rs; rt_val_i = rt;
    expect_val(K_STALL, {31'd0, stl}, name);
    cyc();
  endtask

  task automatic busy(input logic b, input string name);
    expect_val(K_BUSY, {31'd0, b}, name);
    cyc();
  endtask

  task automatic busy_n(input int n, input logic b, input string name);
    for (int i = 0; i < n; i++) busy(b, name);
  endtask

  task automatic rd(input logic hi, input logic [31:0] v, input string name);
    mdu_op_i = hi ? OP_MFHI : OP_MFLO;
    expect_val(hi ? K_HI : K_LO, v, name);
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    busy(1'b0, "reset_busy");
    rd(1'b1, 32'h0, "reset_hi");
    rd(1'b0, 32'h0, "reset_lo");

    issue(OP_MULT, 32'd3, 32'hFFFFFFFE, 1'b1, "mult_stall_T");
    busy_n(5, 1'b1, "mult_busy");
    rd(1'b1, 32'hFFFFFFFF, "mult_hi");
    rd(1'b0, 32'hFFFFFFFA, "mult_lo");

    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, "multu_stall");
    busy_n(5, 1'b1, "multu_busy");
    rd(1'b1, 32'h1, "multu_hi");
    rd(1'b0, 32'hFFFFFFFE, "multu_lo");

    issue(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, "mult_negneg_stall");
    busy_n(5, 1'b1, "mult_negneg_busy");
    rd(1'b1, 32'h0, "mult_negneg_hi");
    rd(1'b0, 32'h6, "mult_negneg_lo");

    issue(OP_MULT, 32'h80000000, 32'h80000000, 1'b1, "mult_min_stall");
    busy_n(5, 1'b1, "mult_min_busy");
    rd(1'b1, 32'h40000000, "mult_min_hi");
    rd(1'b0, 32'h0, "mult_min_lo");

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, "div_stall");
    busy_n(10, 1'b1, "div_busy");
    rd(1'b0, 32'hFFFFFFFD, "div_lo");
    rd(1'b1, 32'hFFFFFFFF, "div_hi");

    issue(OP_DIVU, 32'd7, 32'd0, 1'b1, "divu0_stall");
    busy_n(10, 1'b1, "divu0_busy");
    busy(1'b0, "divu0_done");
    rd(1'b1, 32'hFFFFFFFF, "divu0_hi_unchanged");
    rd(1'b0, 32'hFFFFFFFD, "divu0_lo_unchanged");

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf_stall");
    busy_n(10, 1'b1, "div_ovf_busy");
    rd(1'b0, 32'h80000000, "div_ovf_lo");
    rd(1'b1, 32'h0, "div_ovf_hi");

    // MTLO during a divide-by-zero: must neither write LO nor disturb the counter
    issue(OP_DIVU, 32'd5, 32'd0, 1'b1, "divu0b_stall");
    issue(OP_MTLO, 32'hDEADBEEF, 32'd0, 1'b1, "mtlo_busy_stall");
    busy_n(9, 1'b1, "divu0b_busy");
    busy(1'b0, "divu0b_done");
    rd(1'b0, 32'h80000000, "mtlo_busy_ignored");

    issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0, "mthi_stall");
    rd(1'b1, 32'h12345678, "mthi_read");
    issue(OP_MTLO, 32'hCAFEF00D, 32'd0, 1'b0, "mtlo_stall");
    rd(1'b0, 32'hCAFEF00D, "mtlo_read");

    issue(OP_DIV, 32'd100, 32'd7, 1'b1, "abort_stall");
    busy(1'b1, "abort_busy1");
    busy(1'b1, "abort_busy2");
    reset = 1'b1;
    busy(1'b1, "abort_busy3");
    reset = 1'b0;
    busy(1'b0, "abort_idle");
    rd(1'b1, 32'h0, "abort_hi");
    rd(1'b0, 32'h0, "abort_lo");
    busy_n(12, 1'b0, "abort_no_busy");
    rd(1'b0, 32'h0, "abort_no_commit_lo");
    rd(1'b1, 32'h0, "abort_no_commit_hi");

    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, "madd_setup_lo");
`ifdef MDU_MADD_EN
    issue(OP_MADDU, 32'd1, 32'd1, 1'b1, "maddu_stall");
    busy_n(5, 1'b1, "maddu_busy");
    rd(1'b1, 32'h1, "maddu_hi");
    rd(1'b0, 32'h0, "maddu_lo");
`else
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0, "maddu_nop_stall");
    busy_n(3, 1'b0, "maddu_nop_busy");
    rd(1'b1, 32'h0, "maddu_nop_hi");
    rd(1'b0, 32'hFFFFFFFF, "maddu_nop_lo");
`endif

    cyc();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1);
  end

endmodule
